// File: rtl/dmi_pkg.sv
// dmi_pkg: shared DMI request/response types, op/resp codes and field widths
package dmi_pkg;
  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;
  localparam int DMI_OP_W = 2;
  localparam int DMI_RESP_W = 2;
  localparam logic [DMI_RESP_W-1:0] DMI_SUCCESS = 2'd0;
  localparam logic [DMI_RESP_W-1:0] DMI_FAILED = 2'd2;
  typedef enum logic [DMI_OP_W-1:0] {DMI_NOP, DMI_READ, DMI_WRITE, DMI_RSVD} dmi_op_e;
  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] data;
    dmi_op_e op;
  } dmi_req_t;
  typedef struct packed {
    logic [DMI_DATA_W-1:0] data;
    logic [DMI_RESP_W-1:0] resp;
  } dmi_resp_t;
endpackage

// File: rtl/dmi_reg_bank.sv
// dmi_reg_bank: scratch registers at DMI addresses 1..NUM_REGS with sync clear
module dmi_reg_bank
  import dmi_pkg::*;
#(
  parameter int NUM_REGS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [DMI_ADDR_W-1:0] waddr_i,
  input  logic [DMI_DATA_W-1:0] wdata_i,
  input  logic [DMI_ADDR_W-1:0] raddr_i,
  output logic [DMI_DATA_W-1:0] rdata_o
);
  logic [DMI_DATA_W-1:0] regs [NUM_REGS];
  // storage: reset and functional clear zero everything, otherwise one write per cycle
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REGS; i++)
      if (rst_i || clr_i) regs[i] <= '0;
      else if (we_i && waddr_i == DMI_ADDR_W'(i + 1)) regs[i] <= wdata_i;
  end
  // read port: addresses outside 1..NUM_REGS return zero
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (raddr_i == DMI_ADDR_W'(i + 1)) rdata_o = regs[i];
  end
endmodule

// File: rtl/dmi_reg_responder.sv
// dmi_reg_responder: DMI target executing reads/writes on a register bank with fixed latency
module dmi_reg_responder
  import dmi_pkg::*;
#(
  parameter int          NUM_REGS = 4,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] ID_VALUE = 32'h0000_0B1D
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmi_rst_ni,
  input  logic [40:0] dmi_req_i,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  output logic [33:0] dmi_resp_o,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e state, state_d;
  logic [3:0] cnt, cnt_d;
  dmi_req_t req_q, req_d;
  dmi_resp_t resp_q, resp_d;
  logic we, in_range;
  logic [DMI_DATA_W-1:0] rdata;
  dmi_reg_bank #(.NUM_REGS(NUM_REGS)) u_bank (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(!dmi_rst_ni),
    .we_i(we),
    .waddr_i(req_q.addr),
    .wdata_i(req_q.data),
    .raddr_i(req_q.addr),
    .rdata_o(rdata)
  );
  assign dmi_req_ready_o = state == IDLE;
  assign dmi_resp_valid_o = state == RESP;
  assign dmi_resp_o = resp_q;
  assign in_range = req_q.addr != '0 && req_q.addr <= DMI_ADDR_W'(NUM_REGS);
  // state register: both resets discard any transaction and zero the response
  always_ff @(posedge clk_i) begin
    if (rst_i || !dmi_rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      req_q <= '0;
      resp_q <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      req_q <= req_d;
      resp_q <= resp_d;
    end
  end
  // accept in IDLE, count down in EXEC then decode/commit, hold response until taken
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    req_d = req_q;
    resp_d = resp_q;
    we = 1'b0;
    if (state == IDLE && dmi_req_valid_i) begin
      req_d = dmi_req_t'(dmi_req_i);
      cnt_d = 4'(LATENCY);
      state_d = EXEC;
    end else if (state == EXEC && cnt != '0) begin
      cnt_d = cnt - 4'd1;
    end else if (state == EXEC) begin
      we = req_q.op == DMI_WRITE && in_range;
      resp_d.data = req_q.op != DMI_READ ? '0 : req_q.addr == '0 ? ID_VALUE : in_range ? rdata : '0;
      resp_d.resp = req_q.op == DMI_NOP || we || (req_q.op == DMI_READ && (req_q.addr == '0 || in_range)) ? DMI_SUCCESS : DMI_FAILED;
      state_d = RESP;
    end else if (state == RESP && dmi_resp_ready_i) begin
      state_d = IDLE;
    end
  end
endmodule

// File: tb/tb_dmi_reg_responder.sv
// tb_dmi_reg_responder: directed stimulus with a response scoreboard and monitor
module tb_dmi_reg_responder;
  logic clk_i = 1'b0;
  logic rst_i, dmi_rst_ni, dmi_req_valid_i, dmi_req_ready_o, dmi_resp_valid_o, dmi_resp_ready_i;
  logic [40:0] dmi_req_i;
  logic [33:0] dmi_resp_o;
  logic [33:0] exp_q [$];
  int total = 0;
  int bad = 0;
  localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2, RSV = 2'd3;
  localparam logic [1:0] OK = 2'd0, FL = 2'd2;

  dmi_reg_responder dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .dmi_rst_ni(dmi_rst_ni),
    .dmi_req_i(dmi_req_i),
    .dmi_req_valid_i(dmi_req_valid_i),
    .dmi_req_ready_o(dmi_req_ready_o),
    .dmi_resp_o(dmi_resp_o),
    .dmi_resp_valid_o(dmi_resp_valid_o),
    .dmi_resp_ready_i(dmi_resp_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [33:0] got, input logic [33:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out", name);
  endtask

  // monitor: every response handshake is checked against the oldest expectation
  always @(negedge clk_i) begin
    if (!rst_i && dmi_rst_ni && dmi_resp_valid_o && dmi_resp_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp got=%h exp=none", dmi_resp_o);
      end else chk("resp", dmi_resp_o, exp_q.pop_front());
    end
  end

  task automatic do_req(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                        input bit push, input logic [33:0] e);
    int n = 0;
    while (!dmi_req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n == 50) timeout("req_ready");
    dmi_req_i = {a, d, op};
    dmi_req_valid_i = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk_i);
    @(negedge clk_i);
    dmi_req_valid_i = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!dmi_resp_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n == 50) timeout("resp_valid");
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) timeout("drain");
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1;
    dmi_rst_ni = 1'b1;
    dmi_req_valid_i = 1'b0;
    dmi_req_i = '0;
    dmi_resp_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", 34'(dmi_req_ready_o), 34'd1);
    chk("rst_valid", 34'(dmi_resp_valid_o), 34'd0);
    chk("rst_resp", dmi_resp_o, 34'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    do_req(7'h00, 32'h0, RD, 1, {32'h0000_0B1D, OK});
    chk("lat_t0", 34'(dmi_resp_valid_o), 34'd0);
    @(negedge clk_i);
    chk("lat_t1", 34'(dmi_resp_valid_o), 34'd0);
    @(negedge clk_i);
    chk("lat_t2", 34'(dmi_resp_valid_o), 34'd0);
    @(negedge clk_i);
    chk("lat_t3", 34'(dmi_resp_valid_o), 34'd1);
    drain();
    do_req(7'h02, 32'hDEAD_BEEF, WR, 1, {32'h0, OK});
    do_req(7'h02, 32'h0, RD, 1, {32'hDEAD_BEEF, OK});
    do_req(7'h01, 32'h0, RD, 1, {32'h0, OK});
    do_req(7'h05, 32'h1111_2222, NOP, 1, {32'h0, OK});
    do_req(7'h00, 32'h5555_5555, WR, 1, {32'h0, FL});
    do_req(7'h7F, 32'h0, RD, 1, {32'h0, FL});
    do_req(7'h01, 32'h0000_0005, RSV, 1, {32'h0, FL});
    do_req(7'h01, 32'h0, RD, 1, {32'h0, OK});
    do_req(7'h00, 32'h0, RD, 1, {32'h0000_0B1D, OK});
    do_req(7'h05, 32'h0, RD, 1, {32'h0, FL});
    do_req(7'h05, 32'h7777_7777, WR, 1, {32'h0, FL});
    do_req(7'h04, 32'hA5A5_0F0F, WR, 1, {32'h0, OK});
    do_req(7'h04, 32'h0, RD, 1, {32'hA5A5_0F0F, OK});
    drain();
    dmi_resp_ready_i = 1'b0;
    do_req(7'h02, 32'h0, RD, 1, {32'hDEAD_BEEF, OK});
    wait_valid();
    repeat (20) begin
      chk("bp_valid", 34'(dmi_resp_valid_o), 34'd1);
      chk("bp_data", dmi_resp_o, {32'hDEAD_BEEF, OK});
      chk("bp_ready", 34'(dmi_req_ready_o), 34'd0);
      @(negedge clk_i);
    end
    dmi_resp_ready_i = 1'b1;
    drain();
    do_req(7'h01, 32'h0000_1234, WR, 0, '0);
    dmi_rst_ni = 1'b0;
    @(negedge clk_i);
    dmi_rst_ni = 1'b1;
    repeat (6) begin
      chk("clr_no_resp", 34'(dmi_resp_valid_o), 34'd0);
      @(negedge clk_i);
    end
    do_req(7'h01, 32'h0, RD, 1, {32'h0, OK});
    do_req(7'h02, 32'h0, RD, 1, {32'h0, OK});
    do_req(7'h03, 32'h0000_00C3, WR, 1, {32'h0, OK});
    do_req(7'h03, 32'h0, RD, 1, {32'h0000_00C3, OK});
    drain();
    dmi_resp_ready_i = 1'b0;
    do_req(7'h00, 32'h0, RD, 0, '0);
    wait_valid();
    rst_i = 1'b1;
    dmi_rst_ni = 1'b0;
    @(negedge clk_i);
    chk("both_rst_ready", 34'(dmi_req_ready_o), 34'd1);
    chk("both_rst_valid", 34'(dmi_resp_valid_o), 34'd0);
    chk("both_rst_resp", dmi_resp_o, 34'd0);
    rst_i = 1'b0;
    dmi_rst_ni = 1'b1;
    dmi_resp_ready_i = 1'b1;
    @(negedge clk_i);
    do_req(7'h03, 32'h0, RD, 1, {32'h0, OK});
    do_req(7'h04, 32'h0, RD, 1, {32'h0, OK});
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmi_reg_responder.md
# dmi_reg_responder

DMI target that terminates the core-side request/response channel of the JTAG DMI clock-domain crossing. It decodes 41-bit DMI requests, executes reads and writes against a small 32-bit register bank with a programmable service latency, and returns 34-bit responses under valid/ready flow control. It serves as the bring-up and verification target for the debug transport path and sits in the core clock domain.

## Interface
- NUM_REGS, 4: scratch registers at DMI addresses 0x01..NUM_REGS; legal range 1..126.
- LATENCY, 2: cycles spent in EXEC per transaction; legal range 0..15.
- ID_VALUE, 32'h0000_0B1D: read-only value returned at address 0x00.
- clk_i  in  1  core clock; the block's only clock.
- rst_i  in  1  synchronous, active-high reset.
- dmi_rst_ni  in  1  functional clear from the CDC, active low, sampled on clk_i.
- dmi_req_i  in  41  request {addr[40:34], data[33:2], op[1:0]}.
- dmi_req_valid_i  in  1  request valid.
- dmi_req_ready_o  out  1  request ready.
- dmi_resp_o  out  34  response {data[33:2], resp[1:0]}.
- dmi_resp_valid_o  out  1  response valid.
- dmi_resp_ready_i  in  1  response ready.

## Operation
- Op codes: 0 NOP, 1 READ, 2 WRITE, 3 reserved. Resp codes: 0 SUCCESS, 2 FAILED.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: dmi_req_ready_o = 1. On valid&ready, latch the request, load the latency counter with LATENCY, and go to EXEC.
  - EXEC: decrement the counter. When the counter is 0, compute the response, perform any write, and go to RESP. With LATENCY=0, EXEC lasts exactly one cycle.
  - RESP: dmi_resp_valid_o = 1 and dmi_resp_o is held stable. On dmi_resp_ready_i, go to IDLE.
- Decode rules:
  - NOP: SUCCESS, data 0.
  - READ 0x00: ID_VALUE, SUCCESS.
  - READ 0x01..NUM_REGS: register contents, SUCCESS.
  - WRITE 0x01..NUM_REGS: update the register, SUCCESS, data 0.
  - WRITE 0x00: FAILED, no side effect.
  - Any other address, or op 3: FAILED, data 0, no side effect.
- Only one transaction is outstanding at a time. Requests are never accepted outside IDLE.
- dmi_rst_ni low:
  - Next edge: state goes to IDLE, dmi_resp_valid_o drops, any pending response is discarded, and all scratch registers clear to 0.
  - The request input is ignored while dmi_rst_ni is low.
- rst_i has priority over dmi_rst_ni. Both clear the same state.

## Timing
- Reset values: dmi_req_ready_o=1, dmi_resp_valid_o=0, dmi_resp_o=0, scratch registers 0, state IDLE.
- Request accepted at edge T. Response valid from edge T+1+LATENCY. A write is visible to a READ accepted at or after the handshake edge of its response.
- Minimum request-to-request spacing is LATENCY+3 cycles with dmi_resp_ready_i held high.
- Response backpressure of any length is legal. data and resp stay unchanged until the handshake.
- dmi_req_ready_o is combinational from state only. It has no path from dmi_req_valid_i.
- dmi_rst_ni low in the same cycle as a response handshake: the clear wins, and the handshake still completes because valid was high at that edge.
- dmi_rst_ni low in the same cycle as a request handshake in IDLE: the request is dropped and no response follows.

## Structure
- Shared package dmi_pkg holds:
  - dmi_req_t (41 bits) and dmi_resp_t (34 bits) packed structs.
  - dmi_op_e {NOP, READ, WRITE, RSVD}.
  - resp codes DMI_SUCCESS=2'd0, DMI_FAILED=2'd2.
  - field width constants.
- Sub-module dmi_reg_bank:
  - NUM_REGS×32 storage with a synchronous-clear port.
  - One combinational read port and one write port.
- The FSM, latency counter and decode stay in dmi_reg_responder.

## Test plan
- Reset, then READ 0x00 with LATENCY=2 → SUCCESS, data 0x00000B1D, valid 3 cycles after accept.
- WRITE 0x02 data 0xDEADBEEF, then READ 0x02 → both SUCCESS, read data 0xDEADBEEF. READ 0x01 → 0.
- WRITE 0x00, READ 0x7F, then op 3 at 0x01 → each FAILED, data 0. Follow-up READ 0x00 still returns ID_VALUE.
- Hold dmi_resp_ready_i low for 20 cycles during a READ → valid stays high, data stable, ready_o=0 throughout. The response completes on release.
- Pulse dmi_rst_ni low for 1 cycle while in EXEC after WRITE 0x01 0x1234 → no response is produced, register 0x01 reads 0, and the next request is accepted normally.
- Assert rst_i and dmi_rst_ni together mid-RESP → all outputs return to reset values on the next edge.
